weight_update_engine: RTL and testbench
=======================================

// Module: weight_update_engine
// PURPOSE
//  Reward-modulated synaptic weight updater sitting directly upstream of the weight Memory.
//  Accepts one update request per handshake, does read-modify-write on the Memory port:
//  w_new = clamp(w_old + ((reward * elig) >>> LR_SHIFT), 0, WMAX).
//  Sole master of the Memory we/addr/wdata pins; consumes its registered rdata.
// PARAMETERS
//  ADDR_W    4  weight address width (matches Memory ADDR_W)
//  DW        8  weight width, unsigned (matches Memory DW)
//  RW        4  reward width, signed two's complement
//  EW        4  eligibility-trace width, signed two's complement
//  LR_SHIFT  2  learning-rate arithmetic right shift applied to reward*elig
//  WMAX      (1<<DW)-1  upper weight clamp; lower clamp fixed at 0
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       update request valid
//  req_ready  out  1       engine idle, request accepted on valid&&ready
//  req_addr   in   ADDR_W  synapse address
//  req_reward in   RW      signed reward
//  req_elig   in   EW      signed eligibility trace
//  mem_we     out  1       Memory write enable
//  mem_addr   out  ADDR_W  Memory address
//  mem_wdata  out  DW      Memory write data
//  mem_rdata  in   DW      Memory registered read data (1-cycle latency)
//  done       out  1       one-cycle pulse: update complete
//  w_old      out  DW      weight read, valid with done
//  w_new      out  DW      weight written (or unchanged), valid with done
//  sat        out  1       clamp hit on this update, valid with done
//  sat_count  out  16      saturation event counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; done=0; w_old=0; w_new=0;
//   sat=0; sat_count=0. Async reset mid-operation aborts instantly: mem_we low, no write; memory untouched.
//  FSM: IDLE -(valid&&ready)-> RD -> CALC -> WR -> IDLE. req_ready=1 only in IDLE.
//   Accept edge latches addr/reward/elig; request inputs ignored outside IDLE.
//   RD: mem_addr=latched addr, mem_we=0; Memory samples addr on exiting edge.
//   CALC: mem_rdata valid; delta/clamp computed, registered into mem_wdata, w_old, sat.
//   WR: mem_we=1 for exactly this cycle unless product==0 (zero-delta skip: mem_we stays 0).
//   Exiting WR: done=1 for one cycle (overlaps IDLE), w_new=mem_wdata.
//  Latency: accept edge to done high = 4 edges; max throughput 1 update / 4 cycles.
//  Back-to-back: a request accepted in the done cycle is legal (ready already 1).
//  Arithmetic: prod=signed RW+EW bits; delta=prod>>>LR_SHIFT (floor toward -inf);
//   sum=zero-ext(w_old)+sign-ext(delta) in DW+RW+EW+1 bits; sum<0 -> 0, sum>WMAX -> WMAX, sat=1.
//  mem_addr held stable RD..WR; mem_we never high outside WR.
// CONFIGURATION
//  WUE_SAT_COUNT_EN defined: sat_count increments (saturating at 16'hFFFF) on each done with sat=1.
//  Not defined: counter logic absent, sat_count tied to 0; sat still reported.
// STRUCTURE
//  Package wue_pkg: state_t enum {IDLE,RD,CALC,WR}; localparam SUM_W; clamp function.
//  Sub-module wue_delta_calc: combinational multiply/shift/clamp (w_old,reward,elig -> w_new,sat,zero).
//  Top holds FSM, request latches, Memory drive, done/sat_count registers.
// TESTING (DW=8 RW=4 EW=4 LR_SHIFT=2, Memory instantiated as real model)
//  w=100, reward=3, elig=4 -> prod 12, delta 3; mem_we 1 cycle, mem[a]=103, done 4 edges after accept.
//  w=250, reward=7, elig=7 -> delta 12, sum 262 -> w_new=255, sat=1; sat_count=1 with macro, 0 without.
//  w=5, reward=-8, elig=7 -> delta -14, sum -9 -> w_new=0, sat=1.
//  w=100, reward=-1, elig=1 -> delta -1 (floor) -> 99; reward=0 -> mem_we never high, done pulses, w_new=w_old.
//  req_valid held high with 3 queued requests -> one accept per 4 cycles, ready low in RD/CALC/WR, all written.
//  rst_n low during CALC -> mem_we stays 0, mem[a] unchanged, all outputs at reset values, ready=1 after release.

Source files
------------

// File: rtl/wue_pkg.sv
// Shared types and the weight clamp helper for the reward-modulated weight update engine.
package wue_pkg;

    typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

    // Clamp works at a fixed signed width; callers sign-extend their narrower sums into it.
    localparam int unsigned SUM_W = 32;

    typedef struct packed {
        logic             sat;
        logic [SUM_W-1:0] val;
    } clamp_t;

    function automatic clamp_t clamp_weight(input logic signed [SUM_W-1:0] sum,
                                            input logic signed [SUM_W-1:0] wmax);
        clamp_t r;
        r.sat = 1'b0;
        r.val = sum;
        if (sum < 0) begin
            r.val = '0;
            r.sat = 1'b1;
        end else if (sum > wmax) begin
            r.val = wmax;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wue_delta_calc.sv
// Combinational datapath: w_new = clamp(w_old + ((reward * elig) >>> LR_SHIFT), 0, WMAX).
module wue_delta_calc
    import wue_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned RW       = 4,
    parameter int unsigned EW       = 4,
    parameter int unsigned LR_SHIFT = 2,
    parameter int unsigned WMAX     = (1 << DW) - 1
) (
    input  logic [DW-1:0] w_old,
    input  logic [RW-1:0] reward,
    input  logic [EW-1:0] elig,
    output logic [DW-1:0] w_new,
    output logic          sat,
    output logic          zero
);

    localparam int unsigned PW = RW + EW;
    localparam int unsigned SW = DW + RW + EW + 1;

    logic signed [PW-1:0]    reward_ext;
    logic signed [PW-1:0]    elig_ext;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    delta;
    logic signed [SW-1:0]    sum;
    logic signed [SUM_W-1:0] sum_ext;
    clamp_t                  res;

    assign reward_ext = {{EW{reward[RW-1]}}, reward};
    assign elig_ext   = {{RW{elig[EW-1]}}, elig};
    assign prod       = reward_ext * elig_ext;
    // Arithmetic shift floors toward -inf, so small negative products still give -1.
    assign delta      = prod >>> LR_SHIFT;
    assign sum        = $signed({{(SW-DW){1'b0}}, w_old}) + $signed({{(SW-PW){delta[PW-1]}}, delta});
    assign sum_ext    = {{(SUM_W-SW){sum[SW-1]}}, sum};
    assign res        = clamp_weight(sum_ext, $signed(SUM_W'(WMAX)));

    assign w_new = DW'(res.val);
    assign sat   = res.sat;
    assign zero  = (prod == '0);

endmodule

// File: rtl/weight_update_engine.sv
// Read-modify-write weight updater driving the weight Memory port.
// Optional saturation counter enabled by defining WUE_SAT_COUNT_EN.
module weight_update_engine
    import wue_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned RW       = 4,
    parameter int unsigned EW       = 4,
    parameter int unsigned LR_SHIFT = 2,
    parameter int unsigned WMAX     = (1 << DW) - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [RW-1:0]     req_reward,
    input  logic [EW-1:0]     req_elig,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              done,
    output logic [DW-1:0]     w_old,
    output logic [DW-1:0]     w_new,
    output logic              sat,
    output logic [15:0]       sat_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0]     reward_q;
    logic [EW-1:0]     elig_q;
    logic [DW-1:0]     wdata_q;
    logic [DW-1:0]     w_old_q;
    logic [DW-1:0]     w_new_q;
    logic              sat_q;
    logic              zero_q;
    logic              done_q;

    logic [DW-1:0]     calc_w_new;
    logic              calc_sat;
    logic              calc_zero;
    logic              accept;

    wue_delta_calc #(
        .DW       (DW),
        .RW       (RW),
        .EW       (EW),
        .LR_SHIFT (LR_SHIFT),
        .WMAX     (WMAX)
    ) u_delta_calc (
        .w_old  (mem_rdata),
        .reward (reward_q),
        .elig   (elig_q),
        .w_new  (calc_w_new),
        .sat    (calc_sat),
        .zero   (calc_zero)
    );

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = RD;
            end
            RD:   state_d = CALC;
            CALC: state_d = WR;
            WR: begin
                // A zero product leaves the weight untouched, so the write is skipped.
                mem_we  = !zero_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            reward_q <= '0;
            elig_q   <= '0;
            wdata_q  <= '0;
            w_old_q  <= '0;
            w_new_q  <= '0;
            sat_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == WR);
            if (accept) begin
                addr_q   <= req_addr;
                reward_q <= req_reward;
                elig_q   <= req_elig;
            end
            if (state_q == CALC) begin
                wdata_q <= calc_w_new;
                w_old_q <= mem_rdata;
                sat_q   <= calc_sat;
                zero_q  <= calc_zero;
            end
            if (state_q == WR) w_new_q <= wdata_q;
        end
    end

`ifdef WUE_SAT_COUNT_EN
    logic [15:0] sat_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count_q <= '0;
        end else if (state_q == WR && sat_q && sat_count_q != 16'hFFFF) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count = sat_count_q;
`else
    assign sat_count = 16'h0000;
`endif

    // mem_addr holds the latched address from RD through WR.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign w_old     = w_old_q;
    assign w_new     = w_new_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_weight_update_engine.sv
// Scoreboard bench for weight_update_engine with a registered-read memory model.
module tb_weight_update_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic [3:0] req_reward;
    logic [3:0] req_elig;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       done;
    logic [7:0] w_old;
    logic [7:0] w_new;
    logic       sat;
    logic [15:0] sat_count;

    logic       tb_we = 1'b0;
    logic [3:0] tb_addr = '0;
    logic [7:0] tb_wdata = '0;
    logic [7:0] mem [16];

    typedef struct {
        int addr;
        int w_old;
        int w_new;
        int sat;
        int we;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   we_cnt = 0;

`ifdef WUE_SAT_COUNT_EN
    localparam int SatEn = 1;
`else
    localparam int SatEn = 0;
`endif

    weight_update_engine #(
        .ADDR_W   (4),
        .DW       (8),
        .RW       (4),
        .EW       (4),
        .LR_SHIFT (2),
        .WMAX     (255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_reward (req_reward),
        .req_elig   (req_elig),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .w_old      (w_old),
        .w_new      (w_new),
        .sat        (sat),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on every done pulse.
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("w_old", {24'd0, w_old}, e.w_old);
                check("w_new", {24'd0, w_new}, e.w_new);
                check("sat", {31'd0, sat}, e.sat);
                check("mem_contents", {24'd0, mem[e.addr]}, e.w_new);
                check("we_cycles", we_cnt, e.we);
                check("latency", cyc - e.acc_cyc, 3);
            end
            we_cnt = 0;
        end
    end

    task automatic preload(input int a, input int d);
        tb_addr  = a[3:0];
        tb_wdata = d[7:0];
        tb_we    = 1'b1;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic send(input int a, input int r, input int el, input int wo, input int wn,
                        input int s, input int we, input bit hold, input bit push,
                        output int acc, output int waits);
        exp_t x;
        req_valid  = 1'b1;
        req_addr   = a[3:0];
        req_reward = r[3:0];
        req_elig   = el[3:0];
        waits = 0;
        acc   = 0;
        while (!req_ready && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            x = '{addr: a, w_old: wo, w_new: wn, sat: s, we: we, acc_cyc: cyc};
            sb.push_back(x);
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 0);
        check({tag, "_mem_addr"}, {28'd0, mem_addr}, 0);
        check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_w_old"}, {24'd0, w_old}, 0);
        check({tag, "_w_new"}, {24'd0, w_new}, 0);
        check({tag, "_sat"}, {31'd0, sat}, 0);
        check({tag, "_sat_count"}, {16'd0, sat_count}, 0);
    endtask

    initial begin
        int acc0, acc1, acc2, w0, w1, w2;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_reward = '0;
        req_elig   = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) preload(i, 0);
        preload(1, 100);
        preload(2, 250);
        preload(3, 5);
        preload(4, 100);
        preload(5, 77);
        preload(6, 10);
        preload(7, 20);
        preload(8, 200);
        preload(9, 60);

        // 100 + (12>>>2)
        send(1, 3, 4, 100, 103, 0, 1, 0, 1, acc0, w0);
        wait_drain();
        // 250 + 12 saturates high
        send(2, 7, 7, 250, 255, 1, 1, 0, 1, acc0, w0);
        wait_drain();
        check("sat_count_after_high", {16'd0, sat_count}, SatEn);
        // 5 - 14 saturates low
        send(3, -8, 7, 5, 0, 1, 1, 0, 1, acc0, w0);
        wait_drain();
        check("sat_count_after_low", {16'd0, sat_count}, 2 * SatEn);
        // -1>>>2 floors to -1
        send(4, -1, 1, 100, 99, 0, 1, 0, 1, acc0, w0);
        wait_drain();
        // zero reward: no write
        send(5, 0, 5, 77, 77, 0, 0, 0, 1, acc0, w0);
        wait_drain();

        // Held valid: 10+1, 20-4, 200-8
        send(6, 2, 2, 10, 11, 0, 1, 1, 1, acc0, w0);
        send(7, -3, 5, 20, 16, 0, 1, 1, 1, acc1, w1);
        send(8, 5, -6, 200, 192, 0, 1, 0, 1, acc2, w2);
        check("b2b_spacing_1", acc1 - acc0, 4);
        check("b2b_spacing_2", acc2 - acc1, 4);
        check("b2b_ready_low_1", w1, 3);
        check("b2b_ready_low_2", w2, 3);
        wait_drain();

        // Abort during CALC
        send(9, 7, 7, 0, 0, 0, 0, 0, 0, acc0, w0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(posedge clk);
        #1;
        check("abort_mem_untouched", {24'd0, mem[9]}, 60);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_after", {31'd0, req_ready}, 1);
        check("abort_mem_after", {24'd0, mem[9]}, 60);

        // Post-reset update: 103 + 16
        send(1, -8, -8, 103, 119, 0, 1, 0, 1, acc0, w0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
